// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer control bundle: step-4 events and hazard in, PC control and valid bits out
interface fetch_sequencer_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 stall;
  logic                 branch_taken_step_4;
  logic                 jump_step_4;
  logic                 halt_step_4;
  logic                 is_load_PC;
  logic [1:0]           control_mux_for_PC;
  logic                 valid_step_1;
  logic                 valid_step_2;
  logic                 valid_step_3;
  logic                 valid_step_4;
  logic                 halted;
  logic [CNT_WIDTH-1:0] redirect_count;

  modport master (
    input  stall, branch_taken_step_4, jump_step_4, halt_step_4,
    output is_load_PC, control_mux_for_PC,
    output valid_step_1, valid_step_2, valid_step_3, valid_step_4,
    output halted, redirect_count
  );

  modport slave (
    output stall, branch_taken_step_4, jump_step_4, halt_step_4,
    input  is_load_PC, control_mux_for_PC,
    input  valid_step_1, valid_step_2, valid_step_3, valid_step_4,
    input  halted, redirect_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-stage PC load/select controller with step 1-4 valid tracking
module fetch_sequencer #(
  parameter logic [1:0] SEL_SEQ    = 2'd2,
  parameter logic [1:0] SEL_BRANCH = 2'd1,
  parameter logic [1:0] SEL_JUMP   = 2'd0,
  parameter int         CNT_WIDTH  = 8
) (
  input logic                clk,
  input logic                rst,
  fetch_sequencer_if.master  bus
);
  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    RUN        = 2'd1,
    HALTED     = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [3:0]           valid_q, valid_nx;  // bit 0 = step 1 ... bit 3 = step 4
  logic                 halted_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic jmp, br, hlt, redirect;

  // Step-4 events count only when step 4 holds a live instruction.
  assign jmp      = bus.jump_step_4 & valid_q[3];
  assign br       = bus.branch_taken_step_4 & valid_q[3] & ~bus.jump_step_4;
  assign hlt      = bus.halt_step_4 & valid_q[3];
  assign redirect = (jmp | br) & ~hlt;

  always_comb begin
    bus.control_mux_for_PC = SEL_SEQ;
    if (jmp)
      bus.control_mux_for_PC = SEL_JUMP;
    else if (br)
      bus.control_mux_for_PC = SEL_BRANCH;
  end

  assign bus.is_load_PC = (state == RUN) & ~hlt & (redirect | ~bus.stall);

  always_comb begin
    state_nx = state;
    valid_nx = valid_q;
    case (state)
      RESET_WAIT: begin
        state_nx = RUN;
        valid_nx = 4'b0001;
      end
      RUN: begin
        if (hlt) begin
          state_nx = HALTED;
          valid_nx = 4'b0000;
        end else if (redirect) begin
          valid_nx = 4'b0001;
        end else if (bus.stall) begin
          // Steps 1-2 hold, a bubble enters step 3, step 3 drains into step 4.
          valid_nx = {valid_q[2], 1'b0, valid_q[1], valid_q[0]};
        end else begin
          valid_nx = {valid_q[2:0], 1'b1};
        end
      end
      HALTED: begin
        valid_nx = 4'b0000;
      end
      default: begin
        state_nx = RESET_WAIT;
        valid_nx = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RESET_WAIT;
      valid_q  <= 4'b0000;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state    <= state_nx;
      valid_q  <= valid_nx;
      halted_q <= (state_nx == HALTED);
      if (redirect && (cnt_q != {CNT_WIDTH{1'b1}}))
        cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign bus.valid_step_1   = valid_q[0];
  assign bus.valid_step_2   = valid_q[1];
  assign bus.valid_step_3   = valid_q[2];
  assign bus.valid_step_4   = valid_q[3];
  assign bus.halted         = halted_q;
  assign bus.redirect_count = cnt_q;
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller for the fetch stage. Each cycle it decides whether the PC register loads and which next-PC source the PC mux selects: sequential (pc+1), taken branch (pc+1+IMM), or jump (ext_ADDR). It also keeps the valid bits for steps 1–4. It resolves stalls from the hazard logic and redirects/halts from step 4, and inserts bubbles by clearing valid bits. It drives `is_load_PC` and `control_mux_for_PC` of the step-1 fetch datapath.

## Interface
- `SEL_SEQ`, default 2'd2: mux select for pc_plus_one_step_1
- `SEL_BRANCH`, default 2'd1: mux select for pc_plus_one_plus_IMM_step_4
- `SEL_JUMP`, default 2'd0: mux select for ext_ADDR_step_4
- `CNT_WIDTH`, default 8: width of redirect counter
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `stall` in 1: hazard request; hold steps 1–2, bubble into step 3
- `branch_taken_step_4` in 1: conditional branch in step 4 resolved taken
- `jump_step_4` in 1: step-4 instruction is a jump to ext_ADDR
- `halt_step_4` in 1: step-4 instruction is HALT
- `is_load_PC` out 1: PC load enable
- `control_mux_for_PC` out 2: PC mux select
- `valid_step_1`..`valid_step_4` out 1 each: instruction in that step is architecturally live
- `halted` out 1: 1 in HALTED state
- `redirect_count` out CNT_WIDTH: saturating count of taken redirects

## Operation
- States:
  - RESET_WAIT: entered on rst.
  - RUN
  - HALTED: left only by rst.
- RESET_WAIT → RUN unconditionally after one cycle. PC is not loaded, so address 0 is fetched in the first RUN cycle.
- Qualified step-4 events use `valid_step_4`:
  - jmp = jump_step_4 & valid_step_4
  - br = branch_taken_step_4 & valid_step_4 & ~jump_step_4
  - hlt = halt_step_4 & valid_step_4
  - redirect = (jmp | br) & ~hlt
- Combinational outputs:
  - `control_mux_for_PC` = SEL_JUMP if jmp, else SEL_BRANCH if br, else SEL_SEQ.
  - `is_load_PC` = (state==RUN) & ~hlt & (redirect | ~stall).
- Priority in RUN is hlt > redirect > stall > normal advance. Stall is ignored in a redirect cycle.
- Valid update in RUN:
  - Normal advance: v1<=1, v2<=v1, v3<=v2, v4<=v3.
  - Stall (no redirect/hlt): v1, v2 hold; v3<=0; v4<=v3.
  - Redirect: v1<=1 (target instruction); v2, v3, v4 <=0. This squashes 3 wrong-path instructions.
  - hlt: v1, v2, v3, v4 <=0; state<=HALTED.
- Valid update in RESET_WAIT: v1<=1, others 0.
- Valid update in HALTED: all valid bits 0, `is_load_PC`=0, mux=SEL_SEQ.
- `redirect_count` increments on every redirect cycle and saturates at 2^CNT_WIDTH−1.
- Inputs with `valid_step_4`=0 have no effect: no redirect, no halt, no count.

## Timing
- Reset values (during and after rst edge):
  - state=RESET_WAIT
  - valid_step_1..4=0, halted=0, redirect_count=0
  - is_load_PC=0, control_mux_for_PC=SEL_SEQ
- Select and load are combinational from the current-cycle inputs and state. The PC updates on the same edge.
- Redirect penalty is exactly 3 bubbles. The target is valid in step 1 the cycle after the redirect edge and reaches step 4 three cycles later.
- Stall latency is zero: a stall asserted in cycle N holds the PC at the edge ending N. A stall held K cycles injects K bubbles into step 3.
- rst mid-operation overrides everything at the next edge, including HALTED and a pending redirect.
- `halted` is registered: it goes to 1 the cycle after the hlt edge.

## Test plan
- Reset release, no events → RESET_WAIT for 1 cycle, then is_load_PC=1 and sel=2'd2; valid_step_1..4 rise to 1 over cycles 1..4.
- Steady RUN, br in cycle N → sel=2'd1 and is_load_PC=1 in N; at N+1 valid=1,0,0,0; redirect_count=1.
- jump_step_4 and branch_taken_step_4 both high, valid_step_4=1, stall=1 → sel=2'd0, is_load_PC=1, stall ignored; count increments once.
- stall for 2 cycles in steady RUN → is_load_PC=0 for 2 cycles; valid_step_3=0 for 2 cycles, then valid_step_4=0 for 2 cycles; v1/v2 stay 1.
- halt_step_4 with jump_step_4 → is_load_PC=0, no count increment; next cycle halted=1, all valid 0; stays until rst, then RESET_WAIT.
- 300 consecutive redirects with CNT_WIDTH=8 → redirect_count saturates at 255. Redirect inputs with valid_step_4=0 leave the count and sel unchanged.
